// File: rtl/multi_chan_trig.sv
`default_nettype none
// ============================================================================
// Module   : multi_chan_trig
// Function : N-channel edge/level trigger with AND/OR combine, arm holdoff,
//            N-th match counting, sticky flag and one-cycle strobe.
//            Optional macro TRIG_TSTAMP_EN adds an arm-to-trigger timestamp.
// Revision : 1.0
// ============================================================================
module multi_chan_trig #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 16,
  parameter int TS_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                armed,
  input  logic [NUM_CH-1:0]   chH,
  input  logic [NUM_CH-1:0]   chL,
  input  logic [5*NUM_CH-1:0] trig_cfg,
  input  logic                comb_and,
  input  logic [CNT_W-1:0]    match_cnt,
  input  logic [HOLD_W-1:0]   holdoff,
  output logic                trig_pulse,
  output logic                triggered,
  output logic [TS_W-1:0]     trig_ts,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    ARMED = 2'd2,
    TRIGD = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   s_h_q, s_l_q, p_h_q, p_l_q;
  logic [NUM_CH-1:0]   cond, ch_en;
  logic                hit, hit_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc, need;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                trig_pulse_q, trig_pulse_d;
  logic                triggered_q, triggered_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [4:0] cfg;
    logic       rise, fall, hl, ll;
    assign cfg      = trig_cfg[5*c +: 5];
    assign rise     = s_h_q[c] & ~p_h_q[c];
    assign fall     = ~s_l_q[c] & p_l_q[c];
    assign hl       = s_h_q[c];
    assign ll       = ~s_l_q[c];
    assign ch_en[c] = |cfg;
    assign cond[c]  = (|(cfg[4:1] & {rise, fall, hl, ll})) | cfg[0];
  end

  // Disabled channels are neutral in either combine mode; no enabled channel never hits.
  assign hit = (|ch_en) & (comb_and ? (&(cond | ~ch_en)) : (|(cond & ch_en)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_h_q        <= '0;
      s_l_q        <= '0;
      p_h_q        <= '0;
      p_l_q        <= '0;
      hit_q        <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      trig_pulse_q <= 1'b0;
      triggered_q  <= 1'b0;
    end else begin
      s_h_q        <= chH;
      s_l_q        <= chL;
      // While idle the history follows the fresh sample, so levels present at arm are not edges.
      p_h_q        <= (state_q == IDLE) ? chH : s_h_q;
      p_l_q        <= (state_q == IDLE) ? chL : s_l_q;
      hit_q        <= hit;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      trig_pulse_q <= trig_pulse_d;
      triggered_q  <= triggered_d;
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign need    = (match_cnt == '0) ? CNT_W'(1) : match_cnt;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    trig_pulse_d = 1'b0;
    triggered_d  = triggered_q;
    if (!armed) begin
      state_d     = IDLE;
      cnt_d       = '0;
      hold_d      = '0;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (holdoff != '0) begin
            state_d = HOLD;
            hold_d  = holdoff;
          end else begin
            state_d = ARMED;
          end
        end
        HOLD: begin
          if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
          if (hold_q <= HOLD_W'(1)) state_d = ARMED;
        end
        ARMED: begin
          if (hit_q) begin
            cnt_d = cnt_inc;
            if (({1'b0, cnt_q} + (CNT_W+1)'(1)) >= {1'b0, need}) begin
              state_d      = TRIGD;
              trig_pulse_d = 1'b1;
              triggered_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign trig_pulse = trig_pulse_q;
  assign triggered  = triggered_q;
  assign state_o    = state_q;

`ifdef TRIG_TSTAMP_EN
  logic [TS_W-1:0] ts_q, trig_ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q      <= '0;
      trig_ts_q <= '0;
    end else begin
      if (state_q == IDLE)
        ts_q <= '0;
      else if ((state_q == HOLD || state_q == ARMED) && ts_q != '1)
        ts_q <= ts_q + TS_W'(1);
      // The +1 counts the arm cycle itself.
      if (!armed)
        trig_ts_q <= '0;
      else if (state_q == ARMED && state_d == TRIGD)
        trig_ts_q <= (ts_q == '1) ? ts_q : ts_q + TS_W'(1);
    end
  end

  assign trig_ts = trig_ts_q;
`else
  assign trig_ts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_chan_trig.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_chan_trig
// Function : Scoreboard bench for multi_chan_trig; expected strobe cycles are
//            queued when stimulus is driven and popped when the strobe appears.
// Revision : 1.0
// ============================================================================
module tb_multi_chan_trig;

  logic        clk = 1'b0;
  logic        rst;
  logic        armed;
  logic [3:0]  chH, chL;
  logic [19:0] trig_cfg;
  logic        comb_and;
  logic [7:0]  match_cnt;
  logic [15:0] holdoff;
  logic        trig_pulse, triggered;
  logic [31:0] trig_ts;
  logic [1:0]  state_o;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  multi_chan_trig #(.NUM_CH(4), .CNT_W(8), .HOLD_W(16), .TS_W(32)) dut (
    .clk(clk), .rst(rst), .armed(armed), .chH(chH), .chL(chL),
    .trig_cfg(trig_cfg), .comb_and(comb_and), .match_cnt(match_cnt),
    .holdoff(holdoff), .trig_pulse(trig_pulse), .triggered(triggered),
    .trig_ts(trig_ts), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Strobe monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && trig_pulse) begin
      if (exp_q.size() == 0) check("pulse_unexpected", cyc, 0);
      else check("pulse_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic setup(input logic [4:0] c0, c1, c2, c3, input logic a,
                       input logic [7:0] m, input logic [15:0] h);
    trig_cfg  = {c3, c2, c1, c0};
    comb_and  = a;
    match_cnt = m;
    holdoff   = h;
    tick(1);
  endtask

  task automatic disarm(input string tag);
    armed = 1'b0;
    chH   = '0;
    chL   = '0;
    tick(3);
    check({tag, "_idle_state"}, state_o, 0);
    check({tag, "_idle_trig"}, triggered, 0);
    check({tag, "_leftover"}, exp_q.size(), 0);
  endtask

  task automatic pos_edge0(input logic push_it);
    chH[0] = 1'b1;
    if (push_it) exp_q.push_back(cyc + 3);
    tick(2);
    chH[0] = 1'b0;
    tick(2);
  endtask

  initial begin
    int a0;
    rst = 1'b1; armed = 1'b0; chH = '0; chL = '0;
    trig_cfg = '0; comb_and = 1'b0; match_cnt = 8'd1; holdoff = '0;
    tick(3);
    check("rst_state", state_o, 0);
    check("rst_pulse", trig_pulse, 0);
    check("rst_trig", triggered, 0);
    check("rst_ts", trig_ts, 0);
    rst = 1'b0;
    tick(2);

    // Single rising edge, OR mode, match_cnt 0 behaves as 1.
    setup(5'b10000, 5'b0, 5'b0, 5'b0, 1'b0, 8'd0, 16'd0);
    armed = 1'b1;
    tick(2);
    pos_edge0(1'b1);
    tick(4);
    check("t1_triggered", triggered, 1);
    check("t1_state", state_o, 3);
    disarm("t1");

    // AND: ch0 rise with ch1 high-level qualifier.
    setup(5'b10000, 5'b00100, 5'b0, 5'b0, 1'b1, 8'd1, 16'd0);
    armed = 1'b1;
    tick(2);
    pos_edge0(1'b0);
    tick(3);
    check("t2_no_trig", triggered, 0);
    chH[1] = 1'b1;
    tick(3);
    pos_edge0(1'b1);
    tick(3);
    check("t2_triggered", triggered, 1);
    disarm("t2");

    // Third rising edge triggers; later edges ignored.
    setup(5'b10000, 5'b0, 5'b0, 5'b0, 1'b0, 8'd3, 16'd0);
    armed = 1'b1;
    tick(2);
    for (int i = 1; i <= 5; i++) pos_edge0(i == 3);
    tick(3);
    check("t3_triggered", triggered, 1);
    check("t3_state", state_o, 3);
    disarm("t3");

    // Holdoff 10: early edges ignored, HOLD/ARMED boundary, later edge counts.
    setup(5'b10000, 5'b0, 5'b0, 5'b0, 1'b0, 8'd1, 16'd10);
    armed = 1'b1; a0 = cyc;
    wait_until(a0 + 2);  chH[0] = 1'b1;
    wait_until(a0 + 4);  chH[0] = 1'b0;
    check("t4_hold_state", state_o, 1);
    wait_until(a0 + 8);  chH[0] = 1'b1;
    wait_until(a0 + 10); chH[0] = 1'b0;
    check("t4_hold_last", state_o, 1);
    wait_until(a0 + 11);
    check("t4_armed_entry", state_o, 2);
    check("t4_no_trig", triggered, 0);
    wait_until(a0 + 12); chH[0] = 1'b1; exp_q.push_back(cyc + 3);
    tick(5);
    check("t4_triggered", triggered, 1);
    disarm("t4");
    setup(5'b10000, 5'b0, 5'b0, 5'b0, 1'b0, 8'd1, 16'd0);
    armed = 1'b1;
    tick(1);
    check("t4_hold0_armed", state_o, 2);
    disarm("t4b");

    // Level already high at arm is not an edge; disarm beats a pending hit.
    chH[0] = 1'b1;
    armed  = 1'b1;
    tick(8);
    check("t5_level_at_arm", triggered, 0);
    chH[0] = 1'b0;
    tick(2);
    chH[0] = 1'b1;
    tick(2);
    armed = 1'b0;
    tick(1);
    check("t5_disarm_state", state_o, 0);
    tick(3);
    check("t5_disarm_trig", triggered, 0);
    disarm("t5");

    // Low-level on ch2 in OR mode.
    chL = 4'b0100;
    setup(5'b0, 5'b0, 5'b00010, 5'b0, 1'b0, 8'd1, 16'd0);
    armed = 1'b1;
    tick(3);
    chL[2] = 1'b0; exp_q.push_back(cyc + 3);
    tick(5);
    check("lvl_triggered", triggered, 1);
    disarm("lvl");

    // Don't-care channel hits on the first armed evaluation.
    setup(5'b00001, 5'b0, 5'b0, 5'b0, 1'b0, 8'd1, 16'd0);
    armed = 1'b1; exp_q.push_back(cyc + 2);
    tick(5);
    check("dc_triggered", triggered, 1);
    disarm("dc");

    // All channels disabled in AND mode never hit.
    setup(5'b0, 5'b0, 5'b0, 5'b0, 1'b1, 8'd1, 16'd0);
    armed = 1'b1; chH = 4'hF;
    tick(10);
    check("alloff_no_trig", triggered, 0);
    check("alloff_state", state_o, 2);
    disarm("alloff");

    // Async reset while ARMED with two hits counted.
    setup(5'b10000, 5'b0, 5'b0, 5'b0, 1'b0, 8'd3, 16'd0);
    armed = 1'b1;
    tick(2);
    pos_edge0(1'b0);
    pos_edge0(1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_state", state_o, 0);
    check("t6_rst_trig", triggered, 0);
    check("t6_rst_pulse", trig_pulse, 0);
    armed = 1'b0;
    tick(1);
    rst = 1'b0;
    disarm("t6");

    // Trigger 20 cycles after arm: timestamp 20 with the macro, 0 without.
    setup(5'b10000, 5'b0, 5'b0, 5'b0, 1'b0, 8'd1, 16'd0);
    armed = 1'b1; a0 = cyc;
    wait_until(a0 + 18);
    chH[0] = 1'b1; exp_q.push_back(cyc + 3);
    tick(5);
    check("ts_triggered", triggered, 1);
`ifdef TRIG_TSTAMP_EN
    check("ts_value", trig_ts, 20);
`else
    check("ts_value", trig_ts, 0);
`endif
    disarm("ts");
    check("ts_cleared", trig_ts, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
